// File: rtl/myadder1_stream_pattern_generator.sv
// ---------------------------------------------------------------------------
// myadder1_stream_pattern_generator
//
// Runtime-configurable AXI4-Stream pattern source. A rising edge on ap_start,
// taken while idle, starts one run of cfg_num_packets packets. Each packet is
// cfg_length_bytes long. Every lane carries one element of a sequence that
// continues across packets: seed + k, seed, or seed - k, where k is the global
// element index of the run.
//
// Ports:
//   aclk, areset      clock and synchronous active-high reset
//   ap_start          start request, rising-edge detected
//   ap_idle, ap_done  high while idle / one-cycle pulse at the end of a run
//   cfg_mode          0 increment, 1 constant, 2 decrement, 3 increment
//   cfg_seed          value of element 0
//   cfg_length_bytes  bytes per packet
//   cfg_num_packets   packets per run
//   pkt_count         packets fully sent in the current or last run
//   m_axis_*          AXI4-Stream master output
// ---------------------------------------------------------------------------
module myadder1_stream_pattern_generator #(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 128,
    parameter int unsigned C_NUMBER_BIT_WIDTH   = 32,
    parameter int unsigned C_LENGTH_WIDTH       = 32,
    parameter int unsigned C_PKT_COUNT_WIDTH    = 16
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic                                ap_start,
    output logic                                ap_idle,
    output logic                                ap_done,
    input  logic [1:0]                          cfg_mode,
    input  logic [C_NUMBER_BIT_WIDTH-1:0]       cfg_seed,
    input  logic [C_LENGTH_WIDTH-1:0]           cfg_length_bytes,
    input  logic [C_PKT_COUNT_WIDTH-1:0]        cfg_num_packets,
    output logic [C_PKT_COUNT_WIDTH-1:0]        pkt_count,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                                m_axis_tlast
);

    localparam int unsigned NumLanes  = C_M_AXIS_TDATA_WIDTH / C_NUMBER_BIT_WIDTH;
    localparam int unsigned KeepWidth = C_M_AXIS_TDATA_WIDTH / 8;
    localparam logic [C_LENGTH_WIDTH-1:0] BytesPerBeat = C_LENGTH_WIDTH'(KeepWidth);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                            state_q, state_d;
    logic                              ap_start_r_q;
    logic [1:0]                        mode_q, mode_d;
    logic [C_NUMBER_BIT_WIDTH-1:0]     seed_q, seed_d;
    logic [C_PKT_COUNT_WIDTH-1:0]      num_pkts_q, num_pkts_d;
    logic [C_LENGTH_WIDTH-1:0]         beats_m1_q, beats_m1_d;
    logic [KeepWidth-1:0]              keep_last_q, keep_last_d;
    logic [C_LENGTH_WIDTH-1:0]         beat_cnt_q, beat_cnt_d;
    logic [C_NUMBER_BIT_WIDTH-1:0]     elem_idx_q, elem_idx_d;
    logic [C_PKT_COUNT_WIDTH-1:0]      pkt_count_q, pkt_count_d;
    logic                              tvalid_q, tvalid_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [KeepWidth-1:0]              tkeep_q, tkeep_d;
    logic                              tlast_q, tlast_d;

    logic                              go;
    logic [C_LENGTH_WIDTH-1:0]         beats_m1_calc;
    logic [C_LENGTH_WIDTH-1:0]         rem_calc;
    logic [KeepWidth-1:0]              keep_last_calc;
    logic [C_LENGTH_WIDTH-1:0]         next_cnt;
    logic [C_PKT_COUNT_WIDTH-1:0]      pkt_count_inc;

    // Build one beat: lane i holds element (base + i) of the sequence.
    function automatic logic [C_M_AXIS_TDATA_WIDTH-1:0] gen_beat(
        input logic [1:0]                    mode,
        input logic [C_NUMBER_BIT_WIDTH-1:0] seed,
        input logic [C_NUMBER_BIT_WIDTH-1:0] base
    );
        logic [C_M_AXIS_TDATA_WIDTH-1:0] beat;
        logic [C_NUMBER_BIT_WIDTH-1:0]   k;
        beat = '0;
        for (int i = 0; i < int'(NumLanes); i++) begin
            k = base + C_NUMBER_BIT_WIDTH'(i);
            case (mode)
                2'd1:    beat[i*C_NUMBER_BIT_WIDTH +: C_NUMBER_BIT_WIDTH] = seed;
                2'd2:    beat[i*C_NUMBER_BIT_WIDTH +: C_NUMBER_BIT_WIDTH] = seed - k;
                default: beat[i*C_NUMBER_BIT_WIDTH +: C_NUMBER_BIT_WIDTH] = seed + k;
            endcase
        end
        return beat;
    endfunction

    assign go = ap_start & ~ap_start_r_q;

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        seed_d         = seed_q;
        num_pkts_d     = num_pkts_q;
        beats_m1_d     = beats_m1_q;
        keep_last_d    = keep_last_q;
        beat_cnt_d     = beat_cnt_q;
        elem_idx_d     = elem_idx_q;
        pkt_count_d    = pkt_count_q;
        tvalid_d       = tvalid_q;
        tdata_d        = tdata_q;
        tkeep_d        = tkeep_q;
        tlast_d        = tlast_q;
        beats_m1_calc  = '0;
        rem_calc       = '0;
        keep_last_calc = '1;
        next_cnt       = '0;
        pkt_count_inc  = pkt_count_q + C_PKT_COUNT_WIDTH'(1);

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    mode_d      = cfg_mode;
                    seed_d      = cfg_seed;
                    num_pkts_d  = cfg_num_packets;
                    pkt_count_d = '0;
                    elem_idx_d  = '0;
                    if (cfg_length_bytes == '0 || cfg_num_packets == '0) begin
                        state_d = StDone;
                    end else begin
                        // B - 1 = (L - 1) / bytes_per_beat, valid since L > 0.
                        beats_m1_calc = (cfg_length_bytes - C_LENGTH_WIDTH'(1)) / BytesPerBeat;
                        rem_calc      = cfg_length_bytes % BytesPerBeat;
                        for (int b = 0; b < int'(KeepWidth); b++) begin
                            keep_last_calc[b] = (rem_calc == '0) ||
                                                (C_LENGTH_WIDTH'(b) < rem_calc);
                        end
                        state_d     = StRun;
                        beats_m1_d  = beats_m1_calc;
                        keep_last_d = keep_last_calc;
                        beat_cnt_d  = beats_m1_calc;
                        tvalid_d    = 1'b1;
                        tdata_d     = gen_beat(cfg_mode, cfg_seed, '0);
                        tlast_d     = (beats_m1_calc == '0);
                        tkeep_d     = (beats_m1_calc == '0) ? keep_last_calc : '1;
                    end
                end
            end
            StRun: begin
                if (tvalid_q && m_axis_tready) begin
                    if (tlast_q) begin
                        pkt_count_d = pkt_count_inc;
                    end
                    if (tlast_q && (pkt_count_inc == num_pkts_q)) begin
                        state_d  = StDone;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tkeep_d  = '1;
                    end else begin
                        next_cnt   = tlast_q ? beats_m1_q : (beat_cnt_q - C_LENGTH_WIDTH'(1));
                        beat_cnt_d = next_cnt;
                        elem_idx_d = elem_idx_q + C_NUMBER_BIT_WIDTH'(NumLanes);
                        tdata_d    = gen_beat(mode_q, seed_q, elem_idx_d);
                        tlast_d    = (next_cnt == '0);
                        tkeep_d    = (next_cnt == '0) ? keep_last_q : '1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= StIdle;
            ap_start_r_q <= 1'b0;
            mode_q       <= '0;
            seed_q       <= '0;
            num_pkts_q   <= '0;
            beats_m1_q   <= '0;
            keep_last_q  <= '1;
            beat_cnt_q   <= '0;
            elem_idx_q   <= '0;
            pkt_count_q  <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tkeep_q      <= '1;
            tlast_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ap_start_r_q <= ap_start;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            num_pkts_q   <= num_pkts_d;
            beats_m1_q   <= beats_m1_d;
            keep_last_q  <= keep_last_d;
            beat_cnt_q   <= beat_cnt_d;
            elem_idx_q   <= elem_idx_d;
            pkt_count_q  <= pkt_count_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
        end
    end

    assign ap_idle       = (state_q == StIdle);
    assign ap_done       = (state_q == StDone);
    assign pkt_count     = pkt_count_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_myadder1_stream_pattern_generator.sv
module tb_myadder1_stream_pattern_generator;

    localparam int W   = 128;
    localparam int NBW = 32;
    localparam int LW  = 32;
    localparam int PW  = 16;
    localparam int KW  = W / 8;

    logic           aclk = 1'b0;
    logic           areset;
    logic           ap_start;
    logic           ap_idle;
    logic           ap_done;
    logic [1:0]     cfg_mode;
    logic [NBW-1:0] cfg_seed;
    logic [LW-1:0]  cfg_length_bytes;
    logic [PW-1:0]  cfg_num_packets;
    logic [PW-1:0]  pkt_count;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic [W-1:0]   m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic           m_axis_tlast;

    myadder1_stream_pattern_generator dut (
        .aclk             (aclk),
        .areset           (areset),
        .ap_start         (ap_start),
        .ap_idle          (ap_idle),
        .ap_done          (ap_done),
        .cfg_mode         (cfg_mode),
        .cfg_seed         (cfg_seed),
        .cfg_length_bytes (cfg_length_bytes),
        .cfg_num_packets  (cfg_num_packets),
        .pkt_count        (pkt_count),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tlast     (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Capture results
    logic [W-1:0]  cap_data [16];
    logic [KW-1:0] cap_keep [16];
    logic [15:0]   cap_last;
    int nbeats, ndone, done_at, last_hs, stab_err, valid_seen;

    task automatic kick(input logic [1:0] mode, input logic [NBW-1:0] seed,
                        input logic [LW-1:0] len, input logic [PW-1:0] np);
        cfg_mode         = mode;
        cfg_seed         = seed;
        cfg_length_bytes = len;
        cfg_num_packets  = np;
        ap_start         = 1'b1;
    endtask

    // Observes at each negedge; index i = posedges since ap_start was raised.
    task automatic capture(input int max_cycles, input bit stop_on_done,
                           input logic [31:0] start_pat, input int ready_mode);
        logic [W-1:0]  prev_data;
        logic [KW-1:0] prev_keep;
        logic          prev_last;
        bit            hold;
        bit            r;
        nbeats = 0; ndone = 0; done_at = -1; last_hs = -1; stab_err = 0; valid_seen = 0;
        cap_last = '0;
        hold = 0;
        prev_data = '0; prev_keep = '0; prev_last = 1'b0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge aclk);
            ap_start = (i < 32) ? start_pat[i] : 1'b0;
            if (ap_done) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            if (m_axis_tvalid) valid_seen++;
            if (hold && (!m_axis_tvalid || m_axis_tdata !== prev_data ||
                         m_axis_tkeep !== prev_keep || m_axis_tlast !== prev_last))
                stab_err++;
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 1) == 1);
                default: r = (i > 4);
            endcase
            m_axis_tready = r;
            if (m_axis_tvalid && r) begin
                if (nbeats < 16) begin
                    cap_data[nbeats] = m_axis_tdata;
                    cap_keep[nbeats] = m_axis_tkeep;
                    cap_last[nbeats] = m_axis_tlast;
                end
                nbeats++;
                last_hs = i;
                hold = 0;
            end else if (m_axis_tvalid) begin
                hold = 1;
                prev_data = m_axis_tdata;
                prev_keep = m_axis_tkeep;
                prev_last = m_axis_tlast;
            end else begin
                hold = 0;
            end
            if (stop_on_done && ap_done) break;
        end
        ap_start = 1'b0;
    endtask

    task automatic settle();
        ap_start = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        n_checks++; if (ap_idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", ap_idle); else n_pass++;
        n_checks++; if (ap_done !== 1'b0) $display("FAIL rst_done: got %b want 0", ap_done); else n_pass++;
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); else n_pass++;
        n_checks++; if (m_axis_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); else n_pass++;
        n_checks++; if (m_axis_tkeep !== 16'hFFFF) $display("FAIL rst_tkeep: got %h want ffff", m_axis_tkeep); else n_pass++;
        n_checks++; if (m_axis_tdata !== 128'h0) $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); else n_pass++;
        n_checks++; if (pkt_count !== 16'd0) $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); else n_pass++;
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_default_run();
        kick(2'd0, 32'd0, 32'd64, 16'd1);
        capture(100, 1, 32'h0, 0);
        n_checks++; if (nbeats !== 4) $display("FAIL def_nbeats: got %0d want 4", nbeats); else n_pass++;
        n_checks++; if (cap_data[0] !== 128'h00000003_00000002_00000001_00000000)
            $display("FAIL def_beat0: got %h want 00000003000000020000000100000000", cap_data[0]); else n_pass++;
        n_checks++; if (cap_data[3] !== 128'h0000000f_0000000e_0000000d_0000000c)
            $display("FAIL def_beat3: got %h want 0000000f0000000e0000000d0000000c", cap_data[3]); else n_pass++;
        for (int b = 0; b < 4; b++) begin
            n_checks++; if (cap_keep[b] !== 16'hFFFF)
                $display("FAIL def_tkeep%0d: got %h want ffff", b, cap_keep[b]); else n_pass++;
        end
        n_checks++; if (cap_last[3:0] !== 4'b1000) $display("FAIL def_tlast: got %b want 1000", cap_last[3:0]); else n_pass++;
        n_checks++; if (last_hs !== 4) $display("FAIL def_back_to_back: last handshake at %0d want 4", last_hs); else n_pass++;
        n_checks++; if (done_at !== 5) $display("FAIL def_done_at: got %0d want 5", done_at); else n_pass++;
        n_checks++; if (pkt_count !== 16'd1) $display("FAIL def_pkt_count: got %0d want 1", pkt_count); else n_pass++;
        @(negedge aclk);
        n_checks++; if (ap_done !== 1'b0 || ap_idle !== 1'b1)
            $display("FAIL def_after_done: got done=%b idle=%b want done=0 idle=1", ap_done, ap_idle); else n_pass++;
        n_checks++; if (pkt_count !== 16'd1) $display("FAIL def_pkt_hold: got %0d want 1", pkt_count); else n_pass++;
        settle();
    endtask

    task automatic test_partial_beat();
        kick(2'd0, 32'd10, 32'd20, 16'd1);
        capture(100, 1, 32'h0, 0);
        n_checks++; if (nbeats !== 2) $display("FAIL part_nbeats: got %0d want 2", nbeats); else n_pass++;
        n_checks++; if (cap_data[1][31:0] !== 32'd14) $display("FAIL part_b1_lane0: got %0d want 14", cap_data[1][31:0]); else n_pass++;
        n_checks++; if (cap_keep[1] !== 16'h000F) $display("FAIL part_b1_keep: got %h want 000f", cap_keep[1]); else n_pass++;
        n_checks++; if (cap_last[1:0] !== 2'b10) $display("FAIL part_tlast: got %b want 10", cap_last[1:0]); else n_pass++;
        n_checks++; if (cap_keep[0] !== 16'hFFFF) $display("FAIL part_b0_keep: got %h want ffff", cap_keep[0]); else n_pass++;
        settle();
    endtask

    task automatic test_decrement();
        kick(2'd2, 32'd1, 32'd16, 16'd1);
        capture(100, 1, 32'h0, 0);
        n_checks++; if (nbeats !== 1) $display("FAIL dec_nbeats: got %0d want 1", nbeats); else n_pass++;
        n_checks++; if (cap_data[0] !== 128'hFFFFFFFE_FFFFFFFF_00000000_00000001)
            $display("FAIL dec_data: got %h want fffffffeffffffff0000000000000001", cap_data[0]); else n_pass++;
        n_checks++; if (cap_last[0] !== 1'b1) $display("FAIL dec_tlast: got %b want 1", cap_last[0]); else n_pass++;
        settle();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_beat;
        kick(2'd0, 32'd0, 32'd16, 16'd3);
        capture(200, 1, 32'h0, 1);
        n_checks++; if (nbeats !== 3) $display("FAIL bp_nbeats: got %0d want 3", nbeats); else n_pass++;
        n_checks++; if (cap_last[2:0] !== 3'b111) $display("FAIL bp_tlast: got %b want 111", cap_last[2:0]); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            exp_beat = {32'(4*j+3), 32'(4*j+2), 32'(4*j+1), 32'(4*j)};
            n_checks++; if (cap_data[j] !== exp_beat)
                $display("FAIL bp_beat%0d: got %h want %h", j, cap_data[j], exp_beat); else n_pass++;
        end
        n_checks++; if (stab_err !== 0) $display("FAIL bp_stable: got %0d changes want 0", stab_err); else n_pass++;
        n_checks++; if (done_at !== last_hs + 1 || last_hs < 3)
            $display("FAIL bp_done_at: got %0d want %0d", done_at, last_hs + 1); else n_pass++;
        n_checks++; if (pkt_count !== 16'd3) $display("FAIL bp_pkt_count: got %0d want 3", pkt_count); else n_pass++;
        settle();
    endtask

    task automatic test_start_held();
        kick(2'd1, 32'hA5A5A5A5, 32'd32, 16'd1);
        capture(30, 0, 32'h000F_FFFE, 0);
        n_checks++; if (nbeats !== 2) $display("FAIL hold_nbeats: got %0d want 2", nbeats); else n_pass++;
        n_checks++; if (ndone !== 1) $display("FAIL hold_ndone: got %0d want 1", ndone); else n_pass++;
        n_checks++; if (cap_data[0] !== {4{32'hA5A5A5A5}} || cap_data[1] !== {4{32'hA5A5A5A5}})
            $display("FAIL hold_data: got %h %h want a5a5a5a5 in all lanes", cap_data[0], cap_data[1]); else n_pass++;
        settle();
        // Second rising edge arrives while the first beat is stalled.
        kick(2'd1, 32'hA5A5A5A5, 32'd32, 16'd1);
        capture(20, 0, 32'h0000_0004, 2);
        n_checks++; if (nbeats !== 2) $display("FAIL repulse_nbeats: got %0d want 2", nbeats); else n_pass++;
        n_checks++; if (ndone !== 1) $display("FAIL repulse_ndone: got %0d want 1", ndone); else n_pass++;
        n_checks++; if (stab_err !== 0) $display("FAIL repulse_stable: got %0d changes want 0", stab_err); else n_pass++;
        settle();
    endtask

    task automatic test_empty_runs();
        kick(2'd0, 32'd5, 32'd0, 16'd4);
        capture(20, 1, 32'h0, 0);
        n_checks++; if (valid_seen !== 0) $display("FAIL len0_tvalid: got %0d valid cycles want 0", valid_seen); else n_pass++;
        n_checks++; if (done_at !== 1) $display("FAIL len0_done_at: got %0d want 1", done_at); else n_pass++;
        n_checks++; if (pkt_count !== 16'd0) $display("FAIL len0_pkt_count: got %0d want 0", pkt_count); else n_pass++;
        settle();
        kick(2'd0, 32'd5, 32'd64, 16'd0);
        capture(20, 1, 32'h0, 0);
        n_checks++; if (valid_seen !== 0) $display("FAIL pkt0_tvalid: got %0d valid cycles want 0", valid_seen); else n_pass++;
        n_checks++; if (done_at !== 1) $display("FAIL pkt0_done_at: got %0d want 1", done_at); else n_pass++;
        settle();
    endtask

    task automatic test_mid_reset();
        int dones;
        int valids;
        kick(2'd0, 32'd0, 32'd64, 16'd1);
        m_axis_tready = 1'b1;
        repeat (2) begin
            @(negedge aclk);
            ap_start = 1'b0;
        end
        areset = 1'b1;
        @(negedge aclk);
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL mrst_tvalid: got %b want 0", m_axis_tvalid); else n_pass++;
        n_checks++; if (ap_idle !== 1'b1) $display("FAIL mrst_idle: got %b want 1", ap_idle); else n_pass++;
        n_checks++; if (ap_done !== 1'b0) $display("FAIL mrst_done: got %b want 0", ap_done); else n_pass++;
        areset = 1'b0;
        dones = 0; valids = 0;
        repeat (5) begin
            @(negedge aclk);
            if (ap_done) dones++;
            if (m_axis_tvalid) valids++;
        end
        n_checks++; if (dones !== 0 || valids !== 0)
            $display("FAIL mrst_quiet: got done=%0d valid=%0d want 0 0", dones, valids); else n_pass++;
        kick(2'd0, 32'd7, 32'd16, 16'd1);
        capture(50, 1, 32'h0, 0);
        n_checks++; if (cap_data[0] !== {32'd10, 32'd9, 32'd8, 32'd7} || nbeats !== 1)
            $display("FAIL mrst_restart: got %h (%0d beats) want 0000000a000000090000000800000007", cap_data[0], nbeats); else n_pass++;
        settle();
    endtask

    initial begin
        areset = 1'b1;
        ap_start = 1'b0;
        m_axis_tready = 1'b1;
        cfg_mode = 2'd0;
        cfg_seed = '0;
        cfg_length_bytes = '0;
        cfg_num_packets = '0;
        @(negedge aclk);
        test_reset();
        settle();
        test_default_run();
        test_partial_beat();
        test_decrement();
        test_backpressure();
        test_start_held();
        test_empty_runs();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
